// File: rtl/stepdown_loop_tstate_seq.sv
// Step-down loop cycle sequencer: dead time / min-max on-time / min off-time
// around the Tstate on-time window, with low-side enable and cycle counter.
//
// state | meaning
// IDLE  | loop disabled, both switches off
// DEAD1 | dead time before high-side on-time
// TON   | on-time window (Tstate high)
// DEAD2 | dead time after on-time
// TOFF  | low-side conduction (ls_on high)
module stepdown_loop_tstate_seq #(
  parameter int CW       = 6,
  parameter int TDEAD    = 2,
  parameter int TMIN_ON  = 4,
  parameter int TMAX_ON  = 48,
  parameter int TMIN_OFF = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       trip,
  input  logic       zcd,
  output logic       Tstate,
  output logic       ls_on,
  output logic       maxon_flag,
  output logic [7:0] cycles,
  input  logic       CELG,
  input  logic       CELV,
  input  logic       CELSUB
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD1 = 3'd1,
    TON   = 3'd2,
    DEAD2 = 3'd3,
    TOFF  = 3'd4
  } state_t;

  localparam logic [CW-1:0] DEAD_LAST   = CW'(TDEAD - 1);
  localparam logic [CW-1:0] MINON_LAST  = CW'(TMIN_ON - 1);
  localparam logic [CW-1:0] MAXON_LAST  = CW'(TMAX_ON - 1);
  localparam logic [CW-1:0] MINOFF_LAST = CW'(TMIN_OFF - 1);
  localparam logic [CW-1:0] CNT_SAT     = '1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tstate_q, tstate_d;
  logic          ls_on_q, ls_on_d;
  logic          maxon_q, maxon_d;
  logic [7:0]    cycles_q, cycles_d;
  logic          trip_ok, at_max;

  // Power/substrate pins carry no logic.
  logic unused_pwr;
  assign unused_pwr = CELG ^ CELV ^ CELSUB;

  always_comb begin
    state_d  = state_q;
    maxon_d  = 1'b0;
    cycles_d = cycles_q;
    trip_ok  = 1'b0;
    at_max   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = DEAD1;
      end
      DEAD1: begin
        if (!en)                    state_d = IDLE;
        else if (cnt_q == DEAD_LAST) state_d = TON;
      end
      TON: begin
        trip_ok = trip && (cnt_q >= MINON_LAST);
        at_max  = (cnt_q == MAXON_LAST);
        if (trip_ok || at_max || !en) begin
          state_d = DEAD2;
          maxon_d = at_max && !trip_ok;
          if (cycles_q != 8'hFF) cycles_d = cycles_q + 8'd1;
        end
      end
      DEAD2: begin
        if (cnt_q == DEAD_LAST) state_d = TOFF;
      end
      TOFF: begin
        if (zcd && (cnt_q >= MINOFF_LAST)) state_d = en ? DEAD1 : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Saturate rather than wrap so a long TOFF wait keeps min-off satisfied.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CW'(1);

    tstate_d = (state_d == TON);
    ls_on_d  = (state_d == TOFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tstate_q <= 1'b0;
      ls_on_q  <= 1'b0;
      maxon_q  <= 1'b0;
      cycles_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tstate_q <= tstate_d;
      ls_on_q  <= ls_on_d;
      maxon_q  <= maxon_d;
      cycles_q <= cycles_d;
    end
  end

  assign Tstate     = tstate_q;
  assign ls_on      = ls_on_q;
  assign maxon_flag = maxon_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_stepdown_loop_tstate_seq.sv
// Bench for stepdown_loop_tstate_seq: phase/duration reference model compared
// every cycle, plus directed literal checks of widths, gaps and counters.
module tb_stepdown_loop_tstate_seq;
  localparam int TDEAD    = 2;
  localparam int TMIN_ON  = 4;
  localparam int TMAX_ON  = 48;
  localparam int TMIN_OFF = 6;

  localparam int P_IDLE = 0, P_DEAD1 = 1, P_ON = 2, P_DEAD2 = 3, P_OFF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, trip = 1'b0, zcd = 1'b0;
  logic Tstate, ls_on, maxon_flag;
  logic [7:0] cycles;

  int checks = 0;
  int errors = 0;

  stepdown_loop_tstate_seq #(
    .CW(6), .TDEAD(TDEAD), .TMIN_ON(TMIN_ON), .TMAX_ON(TMAX_ON), .TMIN_OFF(TMIN_OFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trip(trip), .zcd(zcd),
    .Tstate(Tstate), .ls_on(ls_on), .maxon_flag(maxon_flag), .cycles(cycles),
    .CELG(1'b0), .CELV(1'b1), .CELSUB(1'b0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: which phase the loop is in and how many whole cycles
  // have been spent in it; exits are decided from durations, not counters.
  int m_phase = P_IDLE;
  int m_spent = 0;
  int m_cycles = 0;
  int m_maxon = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_spent = 0; m_cycles = 0; m_maxon = 0;
    end else begin
      int nxt;
      int elapsed;
      bit tripped, timeout;
      nxt = m_phase;
      elapsed = m_spent + 1;
      m_maxon = 0;
      case (m_phase)
        P_IDLE:  if (en) nxt = P_DEAD1;
        P_DEAD1: if (!en) nxt = P_IDLE; else if (elapsed == TDEAD) nxt = P_ON;
        P_ON: begin
          tripped = trip && (elapsed >= TMIN_ON);
          timeout = (elapsed == TMAX_ON);
          if (tripped || timeout || !en) begin
            nxt = P_DEAD2;
            m_maxon = (timeout && !tripped) ? 1 : 0;
            if (m_cycles < 255) m_cycles++;
          end
        end
        P_DEAD2: if (elapsed == TDEAD) nxt = P_OFF;
        default: if (zcd && elapsed >= TMIN_OFF) nxt = en ? P_DEAD1 : P_IDLE;
      endcase
      m_spent = (nxt != m_phase) ? 0 : m_spent + 1;
      m_phase = nxt;
    end
  end

  always @(negedge clk) begin
    chk("cmp_tstate", int'(Tstate), (m_phase == P_ON) ? 1 : 0);
    chk("cmp_ls_on", int'(ls_on), (m_phase == P_OFF) ? 1 : 0);
    chk("cmp_maxon", int'(maxon_flag), m_maxon);
    chk("cmp_cycles", int'(cycles), m_cycles);
    chk("no_overlap", int'(Tstate & ls_on), 0);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return Tstate;
      1: return ls_on;
      default: return maxon_flag;
    endcase
  endfunction

  // Counts consecutive sampled cycles (including the current one) with sig==val.
  task automatic run_len(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (sig(sel) === val && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, w, mx, th, lh;
    repeat (3) @(negedge clk);
    chk("rst_tstate", int'(Tstate), 0);
    chk("rst_ls_on", int'(ls_on), 0);
    chk("rst_maxon", int'(maxon_flag), 0);
    chk("rst_cycles", int'(cycles), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Free-running max-on periods.
    en = 1'b1; trip = 1'b0; zcd = 1'b1;
    n = 0;
    while (!Tstate && n < 20) begin @(negedge clk); n++; end
    chk("en_to_tstate", n, TDEAD + 1);
    run_len(0, 1'b1, 200, n);  chk("maxon_width", n, 48);
    chk("maxon_pulse", int'(maxon_flag), 1);
    run_len(1, 1'b0, 200, n);  chk("gap_on_to_ls", n, 2);
    run_len(1, 1'b1, 200, n);  chk("ls_width", n, 6);
    run_len(0, 1'b0, 200, n);  chk("gap_ls_to_on", n, 2);
    chk("cycles_1", int'(cycles), 1);
    mx = 0; th = 0; lh = 0;
    repeat (58) begin
      @(negedge clk);
      mx += int'(maxon_flag); th += int'(Tstate); lh += int'(ls_on);
    end
    chk("period_maxon_cnt", mx, 1);
    chk("period_t_high", th, 48);
    chk("period_ls_high", lh, 6);
    chk("cycles_2", int'(cycles), 2);

    // Trip held from TON entry.
    trip = 1'b1;
    run_len(0, 1'b1, 200, n);  chk("trip_min_width", n, 4);
    chk("trip_no_maxon", int'(maxon_flag), 0);
    run_len(0, 1'b0, 200, n);
    run_len(0, 1'b1, 200, n);  chk("trip_min_width2", n, 4);
    chk("cycles_4", int'(cycles), 4);
    trip = 1'b0;

    // Trip pulses at cnt=2 (ignored) and cnt=10.
    run_len(0, 1'b0, 200, n);
    w = 1;
    repeat (2) begin @(negedge clk); w += int'(Tstate); end
    trip = 1'b1; @(negedge clk); trip = 1'b0; w += int'(Tstate);
    chk("trip_early_ignored", int'(Tstate), 1);
    repeat (7) begin @(negedge clk); w += int'(Tstate); end
    trip = 1'b1; @(negedge clk); trip = 1'b0; w += int'(Tstate);
    chk("trip_cnt10_exit", int'(Tstate), 0);
    chk("trip_cnt10_width", w, 11);

    // Trip coinciding with max-on.
    run_len(0, 1'b0, 200, n);
    repeat (47) @(negedge clk);
    trip = 1'b1; @(negedge clk); trip = 1'b0;
    chk("trip_at_max_exit", int'(Tstate), 0);
    chk("trip_at_max_noflag", int'(maxon_flag), 0);
    chk("cycles_6", int'(cycles), 6);

    // Enable dropped mid-TON.
    run_len(0, 1'b0, 200, n);
    repeat (5) @(negedge clk);
    en = 1'b0; @(negedge clk);
    chk("en_drop_tstate", int'(Tstate), 0);
    zcd = 1'b0;
    run_len(1, 1'b0, 200, n);  chk("en_drop_dead2", n, 2);
    repeat (10) @(negedge clk);
    zcd = 1'b1;
    run_len(1, 1'b1, 200, n);  chk("ls_hold_zcd_low", n + 10, 11);
    repeat (4) @(negedge clk);
    chk("idle_tstate", int'(Tstate), 0);
    chk("idle_ls_on", int'(ls_on), 0);
    chk("cycles_7", int'(cycles), 7);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en   = ($urandom % 16) != 0;
      trip = ($urandom % 8) == 0;
      zcd  = ($urandom % 4) == 0;
    end

    // Async reset mid-TOFF.
    @(negedge clk);
    en = 1'b1; trip = 1'b1; zcd = 1'b0;
    n = 0;
    while (!ls_on && n < 200) begin @(negedge clk); n++; end
    chk("reach_toff", int'(ls_on), 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tstate", int'(Tstate), 0);
    chk("async_rst_ls_on", int'(ls_on), 0);
    chk("async_rst_cycles", int'(cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of the cycle counter.
    en = 1'b1; trip = 1'b1; zcd = 1'b1;
    repeat (300 * 14 + 50) @(negedge clk);
    chk("cycles_sat", int'(cycles), 255);
    repeat (100) @(negedge clk);
    chk("cycles_sat_hold", int'(cycles), 255);

    en = 1'b0; trip = 1'b0; zcd = 1'b0;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
